// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA exponentiation slice.
//   state_t    : sequencer state encoding (CONV_* used only when
//                MONT_EXP_FROM_MONT_EN is defined)
//   K_DEF      : default operand / modulus width
//   E_W_DEF    : default exponent width
//   CONV_ONE   : lane-1 multiplier operand that leaves the Montgomery domain
package rsa_pkg;

  localparam int K_DEF    = 8;
  localparam int E_W_DEF  = 8;
  localparam int CONV_ONE = 1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT       = 3'd2,
    ST_CONV_ISSUE = 3'd3,
    ST_CONV_WAIT  = 3'd4,
    ST_FIN        = 3'd5
  } state_t;

endpackage

// File: rtl/mont_exp_ctrl.sv
// Right-to-left binary modular exponentiation sequencer driving one
// dual-lane Montgomery multiplier (mont_mult).
// Each iteration: lane 0 computes P*P, lane 1 computes Z*P (old P).
// Z is updated from lane 1 only when the current exponent LSB is 1.
//
// Optional feature macro: MONT_EXP_FROM_MONT_EN
//   When defined, a final Z*1 pass converts the result out of the
//   Montgomery domain before it is reported.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ce                  clock enable; all state and outputs hold when low
//   start               request, accepted only in IDLE
//   m, e, n, r_mod      base (Montgomery form), exponent, modulus, R mod n
//   mm_start            one-cycle multiplier start pulse
//   mm_a0/b0, mm_a1/b1  lane operands, held from issue through wait
//   mm_n                modulus for the multiplier
//   mm_done, mm_s0/s1   multiplier completion pulse and results
//   busy, done, result  status, completion pulse, final value
//   dbg_state           current sequencer state
//
// Handshake: start is a single-cycle request with no ready; it is honoured
// only when the sequencer is in IDLE (busy low) and dropped otherwise.
// mm_start/mm_done form a pulse pair: exactly one mm_done is expected per
// mm_start and is only acted on while waiting for it.
module mont_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int K   = K_DEF,
  parameter int E_W = E_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic           start,
  input  logic [K-1:0]   m,
  input  logic [E_W-1:0] e,
  input  logic [K-1:0]   n,
  input  logic [K-1:0]   r_mod,
  output logic           mm_start,
  output logic [K-1:0]   mm_a0,
  output logic [K-1:0]   mm_b0,
  output logic [K-1:0]   mm_a1,
  output logic [K-1:0]   mm_b1,
  output logic [K-1:0]   mm_n,
  input  logic           mm_done,
  input  logic [K-1:0]   mm_s0,
  input  logic [K-1:0]   mm_s1,
  output logic           busy,
  output logic           done,
  output logic [K-1:0]   result,
  output state_t         dbg_state
);

  state_t         state;
  logic [K-1:0]   p_q;
  logic [K-1:0]   z_q;
  logic [E_W-1:0] e_q;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      p_q      <= '0;
      z_q      <= '0;
      e_q      <= '0;
      mm_start <= 1'b0;
      mm_a0    <= '0;
      mm_b0    <= '0;
      mm_a1    <= '0;
      mm_b1    <= '0;
      mm_n     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else if (ce) begin
      // Pulses clear by default; only the issuing states re-raise them.
      mm_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            p_q  <= m;
            z_q  <= r_mod;
            e_q  <= e;
            mm_n <= n;
            busy <= 1'b1;
            if (e == '0) begin
`ifdef MONT_EXP_FROM_MONT_EN
              state <= ST_CONV_ISSUE;
`else
              state <= ST_FIN;
`endif
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          mm_start <= 1'b1;
          mm_a0    <= p_q;
          mm_b0    <= p_q;
          mm_a1    <= z_q;
          mm_b1    <= p_q;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mm_done) begin
            p_q <= mm_s0;
            // Lane 1 is always issued; its product only lands when the bit is set.
            if (e_q[0]) z_q <= mm_s1;
            e_q <= e_q >> 1;
            // Test the bits that survive the shift: no remaining ones -> finished.
            if (e_q[E_W-1:1] == '0) begin
`ifdef MONT_EXP_FROM_MONT_EN
              state <= ST_CONV_ISSUE;
`else
              state <= ST_FIN;
`endif
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
`ifdef MONT_EXP_FROM_MONT_EN
        ST_CONV_ISSUE: begin
          mm_start <= 1'b1;
          mm_a0    <= '0;
          mm_b0    <= '0;
          mm_a1    <= z_q;
          mm_b1    <= K'(CONV_ONE);
          state    <= ST_CONV_WAIT;
        end
        ST_CONV_WAIT: begin
          if (mm_done) begin
            z_q   <= mm_s1;
            state <= ST_FIN;
          end
        end
`endif
        ST_FIN: begin
          result <= z_q;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
